// File: rtl/mc_controller.sv
// Multi-cycle CPU control unit: sequences fetch/decode/execute/memory states and
// drives combinational datapath controls plus a retired-instruction counter.
module mc_controller (
    input  logic       clk,
    input  logic       reset,
    input  logic       run,
    input  logic [3:0] funct,
    input  logic       rd1_zero,
    input  logic       rd1_neg,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       PCEnable,
    output logic       IRWrite,
    output logic       InstrSrc,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       RegWrite,
    output logic       TwoRegs,
    output logic       ALUSub,
    output logic [1:0] PCSrc,
    output logic [1:0] RegWriteSrc,
    output logic       halted,
    output logic [7:0] instr_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEMRD,
        S_MEMWB,
        S_MEMWR,
        S_HALT
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] instr_count_q, instr_count_d;
    logic       retire;
    logic       br_taken;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= S_IDLE;
            instr_count_q <= '0;
        end else begin
            state_q       <= state_d;
            instr_count_q <= instr_count_d;
        end
    end

    // Branch condition for the control-transfer opcodes (1000..1101).
    always_comb begin
        br_taken = 1'b0;
        case (funct)
            4'b1000: br_taken = rd1_zero;
            4'b1001: br_taken = !rd1_zero;
            4'b1010: br_taken = !rd1_neg && !rd1_zero;
            4'b1011: br_taken = rd1_neg;
            4'b1100: br_taken = 1'b1;
            4'b1101: br_taken = 1'b1;
            default: br_taken = 1'b0;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        retire      = 1'b0;
        mem_req     = 1'b0;
        PCEnable    = 1'b0;
        IRWrite     = 1'b0;
        InstrSrc    = 1'b0;
        AdrSrc      = 1'b0;
        MemWrite    = 1'b0;
        RegWrite    = 1'b0;
        TwoRegs     = 1'b0;
        ALUSub      = 1'b0;
        PCSrc       = 2'b00;
        RegWriteSrc = 2'b00;
        halted      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (run) state_d = S_FETCH;
            end
            S_FETCH: begin
                mem_req  = 1'b1;
                InstrSrc = 1'b1;
                if (mem_ready) begin
                    IRWrite  = 1'b1;
                    PCEnable = 1'b1;
                    state_d  = S_DECODE;
                end
            end
            S_DECODE: begin
                case (funct)
                    4'b0000: begin
                        state_d = S_HALT;
                        retire  = 1'b1;
                    end
                    4'b0001, 4'b0100, 4'b0101, 4'b0110, 4'b0111: state_d = S_EXEC;
                    4'b0010: state_d = S_MEMRD;
                    4'b0011: state_d = S_MEMWR;
                    default: begin
                        // Branches, jumps and NOPs all retire here.
                        state_d  = S_FETCH;
                        retire   = 1'b1;
                        PCEnable = br_taken;
                        if (br_taken) PCSrc = (funct == 4'b1101) ? 2'b10 : 2'b01;
                    end
                endcase
            end
            S_EXEC: begin
                RegWrite = 1'b1;
                retire   = 1'b1;
                state_d  = S_FETCH;
                case (funct)
                    4'b0001: RegWriteSrc = 2'b00;
                    4'b0101: begin
                        TwoRegs     = 1'b1;
                        RegWriteSrc = 2'b10;
                    end
                    4'b0110: begin
                        ALUSub      = 1'b1;
                        RegWriteSrc = 2'b10;
                    end
                    4'b0111: begin
                        TwoRegs     = 1'b1;
                        ALUSub      = 1'b1;
                        RegWriteSrc = 2'b10;
                    end
                    default: RegWriteSrc = 2'b10;
                endcase
            end
            S_MEMRD: begin
                mem_req = 1'b1;
                AdrSrc  = 1'b1;
                if (mem_ready) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                RegWrite    = 1'b1;
                RegWriteSrc = 2'b01;
                retire      = 1'b1;
                state_d     = S_FETCH;
            end
            S_MEMWR: begin
                mem_req  = 1'b1;
                AdrSrc   = 1'b1;
                MemWrite = 1'b1;
                if (mem_ready) begin
                    retire  = 1'b1;
                    state_d = S_FETCH;
                end
            end
            S_HALT: begin
                halted = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign instr_count_d = instr_count_q + {7'd0, retire};
    assign instr_count   = instr_count_q;

endmodule

// File: tb/tb_mc_controller.sv
// Directed bench for mc_controller: per-opcode vector table plus hand-written
// sequences for memory stalls, counter wrap, halt and asynchronous reset abort.
module tb_mc_controller;

    logic       clk;
    logic       reset;
    logic       run;
    logic [3:0] funct;
    logic       rd1_zero;
    logic       rd1_neg;
    logic       mem_ready;
    logic       mem_req, PCEnable, IRWrite, InstrSrc, AdrSrc, MemWrite;
    logic       RegWrite, TwoRegs, ALUSub, halted;
    logic [1:0] PCSrc, RegWriteSrc;
    logic [7:0] instr_count;

    int checks   = 0;
    int failures = 0;

    mc_controller dut (
        .clk         (clk),
        .reset       (reset),
        .run         (run),
        .funct       (funct),
        .rd1_zero    (rd1_zero),
        .rd1_neg     (rd1_neg),
        .mem_ready   (mem_ready),
        .mem_req     (mem_req),
        .PCEnable    (PCEnable),
        .IRWrite     (IRWrite),
        .InstrSrc    (InstrSrc),
        .AdrSrc      (AdrSrc),
        .MemWrite    (MemWrite),
        .RegWrite    (RegWrite),
        .TwoRegs     (TwoRegs),
        .ALUSub      (ALUSub),
        .PCSrc       (PCSrc),
        .RegWriteSrc (RegWriteSrc),
        .halted      (halted),
        .instr_count (instr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Output word: {mem_req,PCEnable,IRWrite,InstrSrc,AdrSrc,MemWrite,RegWrite,TwoRegs,ALUSub,PCSrc,RegWriteSrc,halted}
    localparam logic [13:0] W_ZERO     = 14'b0_0_0_0_0_0_0_0_0_00_00_0;
    localparam logic [13:0] W_FETCH_RD = 14'b1_1_1_1_0_0_0_0_0_00_00_0;
    localparam logic [13:0] W_FETCH_WT = 14'b1_0_0_1_0_0_0_0_0_00_00_0;
    localparam logic [13:0] W_BR_IMM   = 14'b0_1_0_0_0_0_0_0_0_01_00_0;
    localparam logic [13:0] W_BR_RD1   = 14'b0_1_0_0_0_0_0_0_0_10_00_0;
    localparam logic [13:0] W_SETN     = 14'b0_0_0_0_0_0_1_0_0_00_00_0;
    localparam logic [13:0] W_COPY     = 14'b0_0_0_0_0_0_1_0_0_00_10_0;
    localparam logic [13:0] W_ADD      = 14'b0_0_0_0_0_0_1_1_0_00_10_0;
    localparam logic [13:0] W_NEG      = 14'b0_0_0_0_0_0_1_0_1_00_10_0;
    localparam logic [13:0] W_SUB      = 14'b0_0_0_0_0_0_1_1_1_00_10_0;
    localparam logic [13:0] W_MEMRD    = 14'b1_0_0_0_1_0_0_0_0_00_00_0;
    localparam logic [13:0] W_MEMWB    = 14'b0_0_0_0_0_0_1_0_0_00_01_0;
    localparam logic [13:0] W_MEMWR    = 14'b1_0_0_0_1_1_0_0_0_00_00_0;
    localparam logic [13:0] W_HALT     = 14'b0_0_0_0_0_0_0_0_0_00_00_1;

    typedef struct {
        logic [3:0]  funct;
        logic        z;
        logic        n;
        int unsigned lat;
        logic [13:0] c2;
        logic [13:0] c3;
        logic [13:0] c4;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic [3:0] f, input logic z, input logic n,
                                input int unsigned lat, input logic [13:0] c2,
                                input logic [13:0] c3, input logic [13:0] c4);
        vec_t v;
        v.funct = f; v.z = z; v.n = n; v.lat = lat;
        v.c2 = c2; v.c3 = c3; v.c4 = c4;
        return v;
    endfunction

    function automatic logic [13:0] obs();
        return {mem_req, PCEnable, IRWrite, InstrSrc, AdrSrc, MemWrite, RegWrite,
                TwoRegs, ALUSub, PCSrc, RegWriteSrc, halted};
    endfunction

    task automatic chk(input string name, input logic [13:0] exp);
        logic [13:0] got;
        got = obs();
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: outputs got=%b want=%b", name, got, exp);
        end
    endtask

    task automatic chk_cnt(input string name, input logic [7:0] exp);
        checks++;
        if (instr_count !== exp) begin
            failures++;
            $display("FAIL %s: instr_count got=%0d want=%0d", name, instr_count, exp);
        end
    endtask

    // Advance one clock edge, then sample mid-cycle once inputs have settled.
    task automatic next_cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
        run   = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    // From just after reset release: request run and land in FETCH.
    task automatic start_run();
        run = 1'b1;
        next_cyc();
    endtask

    logic [7:0] exp_cnt;

    initial begin
        reset = 1'b0; run = 1'b0; funct = 4'b1110;
        rd1_zero = 1'b0; rd1_neg = 1'b0; mem_ready = 1'b1;

        #3;
        chk("reset_outputs", W_ZERO);
        chk_cnt("reset_count", 8'd0);

        @(posedge clk);
        #1;
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            next_cyc();
            chk($sformatf("idle_hold%0d", i), W_ZERO);
        end

        funct = 4'b0101;
        start_run();

        vecs.push_back(mk(4'b0101, 0, 0, 3, W_ZERO,   W_ADD,   W_ZERO));
        vecs.push_back(mk(4'b0001, 0, 0, 3, W_ZERO,   W_SETN,  W_ZERO));
        vecs.push_back(mk(4'b0010, 0, 0, 4, W_ZERO,   W_MEMRD, W_MEMWB));
        vecs.push_back(mk(4'b0011, 0, 0, 3, W_ZERO,   W_MEMWR, W_ZERO));
        vecs.push_back(mk(4'b0100, 0, 0, 3, W_ZERO,   W_COPY,  W_ZERO));
        vecs.push_back(mk(4'b0110, 0, 0, 3, W_ZERO,   W_NEG,   W_ZERO));
        vecs.push_back(mk(4'b0111, 0, 0, 3, W_ZERO,   W_SUB,   W_ZERO));
        vecs.push_back(mk(4'b1000, 1, 0, 2, W_BR_IMM, W_ZERO,  W_ZERO));
        vecs.push_back(mk(4'b1000, 0, 0, 2, W_ZERO,   W_ZERO,  W_ZERO));
        vecs.push_back(mk(4'b1001, 0, 1, 2, W_BR_IMM, W_ZERO,  W_ZERO));
        vecs.push_back(mk(4'b1001, 1, 0, 2, W_ZERO,   W_ZERO,  W_ZERO));
        vecs.push_back(mk(4'b1010, 0, 1, 2, W_ZERO,   W_ZERO,  W_ZERO));
        vecs.push_back(mk(4'b1010, 0, 0, 2, W_BR_IMM, W_ZERO,  W_ZERO));
        vecs.push_back(mk(4'b1010, 1, 0, 2, W_ZERO,   W_ZERO,  W_ZERO));
        vecs.push_back(mk(4'b1011, 0, 1, 2, W_BR_IMM, W_ZERO,  W_ZERO));
        vecs.push_back(mk(4'b1011, 1, 0, 2, W_ZERO,   W_ZERO,  W_ZERO));
        vecs.push_back(mk(4'b1100, 0, 0, 2, W_BR_IMM, W_ZERO,  W_ZERO));
        vecs.push_back(mk(4'b1101, 1, 1, 2, W_BR_RD1, W_ZERO,  W_ZERO));
        vecs.push_back(mk(4'b1110, 0, 0, 2, W_ZERO,   W_ZERO,  W_ZERO));
        vecs.push_back(mk(4'b1111, 0, 0, 2, W_ZERO,   W_ZERO,  W_ZERO));

        exp_cnt = 8'd0;
        foreach (vecs[i]) begin
            funct = vecs[i].funct; rd1_zero = vecs[i].z; rd1_neg = vecs[i].n;
            mem_ready = 1'b1;
            #1;
            chk($sformatf("v%0d_f%b_fetch", i, vecs[i].funct), W_FETCH_RD);
            next_cyc();
            chk($sformatf("v%0d_f%b_decode", i, vecs[i].funct), vecs[i].c2);
            if (vecs[i].lat >= 3) begin
                next_cyc();
                chk($sformatf("v%0d_f%b_cyc3", i, vecs[i].funct), vecs[i].c3);
            end
            if (vecs[i].lat >= 4) begin
                next_cyc();
                chk($sformatf("v%0d_f%b_cyc4", i, vecs[i].funct), vecs[i].c4);
            end
            next_cyc();
            exp_cnt = exp_cnt + 8'd1;
            chk($sformatf("v%0d_f%b_back_to_fetch", i, vecs[i].funct), W_FETCH_RD);
            chk_cnt($sformatf("v%0d_f%b_count", i, vecs[i].funct), exp_cnt);
        end

        // LOADR with stalled fetch and a 3-cycle memory read stall.
        funct = 4'b0010; rd1_zero = 1'b0; rd1_neg = 1'b0; mem_ready = 1'b0;
        #1;
        chk("ld_fetch_wait0", W_FETCH_WT);
        next_cyc();
        chk("ld_fetch_wait1", W_FETCH_WT);
        mem_ready = 1'b1;
        #1;
        chk("ld_fetch_ready", W_FETCH_RD);
        next_cyc();
        chk("ld_decode", W_ZERO);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            mem_ready = 1'b0;
            #1;
            chk($sformatf("ld_memrd_stall%0d", i), W_MEMRD);
        end
        @(posedge clk);
        #1;
        mem_ready = 1'b1;
        #1;
        chk("ld_memrd_done", W_MEMRD);
        next_cyc();
        chk("ld_memwb", W_MEMWB);
        next_cyc();
        exp_cnt = exp_cnt + 8'd1;
        chk("ld_back_to_fetch", W_FETCH_RD);
        chk_cnt("ld_count", exp_cnt);

        // 256 NOPs starting from a freshly reset counter.
        do_reset();
        funct = 4'b1110;
        start_run();
        chk_cnt("wrap_start", 8'd0);
        for (int i = 1; i <= 256; i++) begin
            next_cyc();
            next_cyc();
            if (i == 255) chk_cnt("wrap_255", 8'd255);
        end
        chk_cnt("wrap_to_zero", 8'd0);
        chk("wrap_in_fetch", W_FETCH_RD);

        // STORER stalled in MEMWR, then asynchronous reset mid-access.
        funct = 4'b0011;
        next_cyc();
        chk("st_decode", W_ZERO);
        @(posedge clk);
        #1;
        mem_ready = 1'b0;
        #1;
        chk("st_memwr_stall", W_MEMWR);
        next_cyc();
        chk("st_memwr_stall2", W_MEMWR);
        #1;
        reset = 1'b0;
        #1;
        chk("st_abort_outputs", W_ZERO);
        chk_cnt("st_abort_count", 8'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        run = 1'b0;
        mem_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            next_cyc();
            chk($sformatf("post_abort_idle%0d", i), W_ZERO);
        end

        // HALT retires in DECODE and is sticky regardless of run.
        funct = 4'b0000;
        start_run();
        chk("halt_fetch", W_FETCH_RD);
        next_cyc();
        chk("halt_decode", W_ZERO);
        next_cyc();
        chk("halt_state", W_HALT);
        chk_cnt("halt_count", 8'd1);
        for (int i = 0; i < 4; i++) begin
            run = (i % 2 == 0) ? 1'b0 : 1'b1;
            funct = 4'b0101;
            next_cyc();
            chk($sformatf("halt_sticky%0d", i), W_HALT);
        end
        chk_cnt("halt_count_stable", 8'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
